wishbone_burst_master: RTL

//  Parametrised Wishbone B4 classic-cycle bus master. Executes single or incrementing multi-beat read/write

---
 rtl/wishbone_burst_master_pkg.sv | 18 +
 rtl/wishbone_burst_master_if.sv | 25 ++
 rtl/wishbone_burst_master_timeout.sv | 22 ++
 rtl/wishbone_burst_master.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/wishbone_burst_master_pkg.sv
// Shared definitions for the Wishbone burst master: FSM encodings, status codes
// and default bus widths.
package wishbone_burst_master_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] WB_ST_OK      = 2'd0;
    localparam logic [1:0] WB_ST_ERR     = 2'd1;
    localparam logic [1:0] WB_ST_TIMEOUT = 2'd2;

    localparam int WB_ADDR_WIDTH_DEF = 32;
    localparam int WB_DATA_WIDTH_DEF = 64;

endpackage

// File: rtl/wishbone_burst_master_if.sv
// Wishbone B4 classic-cycle bus signals, named from the master's point of view.
interface wishbone_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH/8-1:0] sel_o;
    logic                    we_o;
    logic                    cyc_o;
    logic                    stb_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    ack_i;
    logic                    err_i;

    modport master (
        output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/wishbone_burst_master_timeout.sv
// No-ack watchdog: counts enabled cycles; expired marks the limit-th cycle.
// A zero limit never expires.
module wb_timeout_counter #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable,
    input  logic          clear,
    input  logic [CW-1:0] limit,
    output logic          expired
);
    logic [CW-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + CW'(1);
    end

    assign expired = enable && (limit != '0) && (count == limit - CW'(1));
endmodule

// File: rtl/wishbone_burst_master.sv
// Wishbone B4 classic-cycle burst master: single or incrementing bursts from a
// valid/ready command port, read beats streamed out, one done pulse with status.
module wishbone_burst_master
    import wishbone_burst_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH_DEF,
    parameter int LEN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic                    wr_valid_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    wr_ready_o,
    output logic                    rd_valid_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_last_o,
    output logic                    done_o,
    output logic [1:0]              status_o,
    output logic                    busy_o,
    output logic [DATA_WIDTH-1:0]   last_read_value_o,
    wishbone_burst_master_if.master wb
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [2:0]              state, next_state;
    logic [LEN_WIDTH-1:0]    len_q, beat_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [DATA_WIDTH/8-1:0] sel_q;
    logic                    we_q, cyc_q, stb_q;
    logic                    accept, last_beat, tmo_expired, tmo_clear;

    assign accept    = (state == ST_IDLE) && cmd_valid_i && cmd_ready_o;
    assign last_beat = (beat_q == len_q);
    assign tmo_clear = (next_state == ST_STROBE) && (state != ST_STROBE);

    wb_timeout_counter #(.CW(TW)) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enable  (state == ST_STROBE),
        .clear   (tmo_clear),
        .limit   (TW'(TIMEOUT_CYCLES)),
        .expired (tmo_expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = cmd_we_i ? ST_LOAD_W : ST_STROBE;
            ST_LOAD_W: if (wr_valid_i) next_state = ST_STROBE;
            ST_STROBE: begin
                // err_i takes priority over a simultaneous ack_i
                if (wb.err_i)        next_state = ST_RESP;
                else if (wb.ack_i)   next_state = last_beat ? ST_RESP : ST_GAP;
                else if (tmo_expired) next_state = ST_RESP;
            end
            ST_GAP:    next_state = we_q ? ST_LOAD_W : ST_STROBE;
            ST_RESP:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Bus controls are registered from next_state so they change cleanly on the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            cmd_ready_o       <= 1'b0;
            len_q             <= '0;
            beat_q            <= '0;
            adr_q             <= '0;
            dat_q             <= '0;
            sel_q             <= '0;
            we_q              <= 1'b0;
            cyc_q             <= 1'b0;
            stb_q             <= 1'b0;
            rd_valid_o        <= 1'b0;
            rd_data_o         <= '0;
            rd_last_o         <= 1'b0;
            done_o            <= 1'b0;
            status_o          <= WB_ST_OK;
            last_read_value_o <= '0;
        end else begin
            state       <= next_state;
            cmd_ready_o <= (next_state == ST_IDLE);
            cyc_q       <= (next_state == ST_LOAD_W) || (next_state == ST_STROBE) ||
                           (next_state == ST_GAP);
            stb_q       <= (next_state == ST_STROBE);
            done_o      <= (next_state == ST_RESP);
            rd_valid_o  <= 1'b0;
            rd_last_o   <= 1'b0;

            if (accept) begin
                adr_q  <= cmd_addr_i;
                sel_q  <= cmd_sel_i;
                we_q   <= cmd_we_i;
                len_q  <= cmd_len_i;
                beat_q <= '0;
            end

            if (state == ST_LOAD_W && wr_valid_i) dat_q <= wr_data_i;

            if (state == ST_STROBE && !wb.err_i && wb.ack_i) begin
                if (!we_q) begin
                    rd_valid_o        <= 1'b1;
                    rd_data_o         <= wb.dat_i;
                    last_read_value_o <= wb.dat_i;
                    rd_last_o         <= last_beat;
                end
                if (!last_beat) begin
                    beat_q <= beat_q + LEN_WIDTH'(1);
                    adr_q  <= adr_q + STEP;
                end
            end

            if (state == ST_STROBE && next_state == ST_RESP) begin
                status_o <= wb.err_i ? WB_ST_ERR : (wb.ack_i ? WB_ST_OK : WB_ST_TIMEOUT);
                we_q     <= 1'b0;
            end
        end
    end

    assign busy_o     = (state != ST_IDLE);
    assign wr_ready_o = (state == ST_LOAD_W);

    assign wb.adr_o = adr_q;
    assign wb.dat_o = dat_q;
    assign wb.sel_o = sel_q;
    assign wb.we_o  = we_q;
    assign wb.cyc_o = cyc_q;
    assign wb.stb_o = stb_q;
endmodule
